// File: rtl/l1_pkg.sv
// Shared types, widths and line/word helpers for the L1 data cache.
package l1_pkg;

    localparam int LINE_BITS  = 512;
    localparam int WORD_BITS  = 32;
    localparam int WORD_SEL_W = 4;   // 16 words per line

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_WB_REQ,
        S_WB_WAIT,
        S_FILL_REQ,
        S_FILL_WAIT,
        S_RESPOND
    } state_t;

    // Word i lives at line bits [511-32*i -: 32], the same order L2 uses.
    function automatic logic [WORD_BITS-1:0] word_slice(
        input logic [LINE_BITS-1:0]  line,
        input logic [WORD_SEL_W-1:0] sel
    );
        return line[LINE_BITS-1-WORD_BITS*int'(sel) -: WORD_BITS];
    endfunction

    // Return the line with word 'sel' replaced by 'word'.
    function automatic logic [LINE_BITS-1:0] word_merge(
        input logic [LINE_BITS-1:0]  line,
        input logic [WORD_SEL_W-1:0] sel,
        input logic [WORD_BITS-1:0]  word
    );
        logic [LINE_BITS-1:0] merged;
        merged = line;
        merged[LINE_BITS-1-WORD_BITS*int'(sel) -: WORD_BITS] = word;
        return merged;
    endfunction

endpackage

// File: rtl/l1_line_store.sv
// Line storage for the direct-mapped cache: valid, dirty, tag and data per set.
// One combinational read port and one write port that can merge a single word.
module l1_line_store
    import l1_pkg::*;
#(
    parameter int SETS  = 16,
    parameter int IDX_W = $clog2(SETS),
    parameter int TAG_W = 26 - IDX_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic                  rd_valid,
    output logic                  rd_dirty,
    output logic [TAG_W-1:0]      rd_tag,
    output logic [LINE_BITS-1:0]  rd_line,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [TAG_W-1:0]      wr_tag,
    input  logic                  wr_valid,
    input  logic                  wr_dirty,
    input  logic [LINE_BITS-1:0]  wr_line,
    input  logic                  wr_merge,
    input  logic [WORD_SEL_W-1:0] wr_word_sel,
    input  logic [WORD_BITS-1:0]  wr_word
);

    logic [SETS-1:0]      valid_q;
    logic [SETS-1:0]      dirty_q;
    logic [TAG_W-1:0]     tag_q  [SETS];
    logic [LINE_BITS-1:0] data_q [SETS];

    assign rd_valid = valid_q[rd_idx];
    assign rd_dirty = dirty_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_line  = data_q[rd_idx];

    // Status bits: cleared on reset so every line starts invalid and clean.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values, independent of block ordering.
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= wr_valid;
            dirty_q[wr_idx] <= wr_dirty;
        end
    end

    // Tag and data arrays: written whole-line, optionally with one word merged in.
    always_ff @(posedge clk) begin
        // NOTE: tag/data are deliberately not reset; valid_q masks them, and a
        // reset here would turn the array into thousands of resettable flops.
        if (wr_en) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_merge ? word_merge(wr_line, wr_word_sel, wr_word)
                                       : wr_line;
        end
    end

endmodule

// File: rtl/l1_dcache.sv
// Direct-mapped, write-back, write-allocate L1 data cache. Serves single 32-bit
// CPU loads/stores and moves whole 64-byte lines to/from L2.
module l1_dcache
    import l1_pkg::*;
#(
    parameter int SETS       = 16,
    parameter int LINE_BYTES = 64,
    parameter int IDX_W      = $clog2(SETS),
    parameter int TAG_W      = 26 - IDX_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [31:0]          cpu_addr,
    input  logic [31:0]          cpu_wdata,
    output logic [31:0]          cpu_rdata,
    output logic                 cpu_ready,
    output logic                 cpu_busy,
    output logic                 l2_request,
    output logic                 l2_write_en,
    output logic [31:0]          l2_paddr,
    output logic [LINE_BITS-1:0] l2_write_data,
    input  logic [LINE_BITS-1:0] l2_data_out,
    input  logic                 l2_done
);

    localparam int OFF_W = $clog2(LINE_BYTES);

    state_t          state;
    logic [31:2]     addr_q;
    logic            we_q;
    logic [31:0]     wdata_q;
    logic            done_q;
    logic            done_rise;

    logic [IDX_W-1:0]      idx_q;
    logic [TAG_W-1:0]      tag_q;
    logic [WORD_SEL_W-1:0] word_sel;

    logic                  rd_valid;
    logic                  rd_dirty;
    logic [TAG_W-1:0]      rd_tag;
    logic [LINE_BITS-1:0]  rd_line;
    logic                  hit;

    logic                  wr_en;
    logic [TAG_W-1:0]      wr_tag;
    logic                  wr_valid;
    logic                  wr_dirty;
    logic [LINE_BITS-1:0]  wr_line;
    logic                  wr_merge;

    // Byte-offset bits within a word carry no information for word accesses.
    logic unused_byte_offset;
    assign unused_byte_offset = ^cpu_addr[1:0];

    assign idx_q     = addr_q[OFF_W +: IDX_W];
    assign tag_q     = addr_q[31 -: TAG_W];
    assign word_sel  = addr_q[OFF_W-1:2];
    assign hit       = rd_valid && (rd_tag == tag_q);
    // Only a fresh 0->1 transition completes a wait; a level left high from the
    // previous transaction must not.
    assign done_rise = l2_done && !done_q;

    l1_line_store #(
        .SETS  (SETS),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_store (
        .clk         (clk),
        .reset       (reset),
        .rd_idx      (idx_q),
        .rd_valid    (rd_valid),
        .rd_dirty    (rd_dirty),
        .rd_tag      (rd_tag),
        .rd_line     (rd_line),
        .wr_en       (wr_en),
        .wr_idx      (idx_q),
        .wr_tag      (wr_tag),
        .wr_valid    (wr_valid),
        .wr_dirty    (wr_dirty),
        .wr_line     (wr_line),
        .wr_merge    (wr_merge),
        .wr_word_sel (word_sel),
        .wr_word     (wdata_q)
    );

    // Previous value of l2_done, tracked in every state so edge detection is
    // correct the moment a wait state is entered.
    always_ff @(posedge clk) begin
        done_q <= l2_done;
    end

    // Line-store write requests: store hit, writeback completion, fill install.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one
        // unassigned and infers a latch.
        wr_en    = 1'b0;
        wr_tag   = rd_tag;
        wr_valid = 1'b1;
        wr_dirty = 1'b0;
        wr_line  = rd_line;
        wr_merge = 1'b0;
        if (!reset) begin
            case (state)
                S_LOOKUP: begin
                    if (hit && we_q) begin
                        wr_en    = 1'b1;
                        wr_dirty = 1'b1;
                        wr_merge = 1'b1;
                    end
                end
                S_WB_WAIT: begin
                    // Victim is now in L2: keep the line, clear dirty.
                    if (done_rise) begin
                        wr_en = 1'b1;
                    end
                end
                S_FILL_WAIT: begin
                    if (done_rise) begin
                        wr_en    = 1'b1;
                        wr_tag   = tag_q;
                        wr_line  = l2_data_out;
                        wr_merge = we_q;
                        wr_dirty = we_q;
                    end
                end
                default: ;
            endcase
        end
    end

    // Main controller with registered CPU and L2 outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            addr_q        <= '0;
            we_q          <= 1'b0;
            wdata_q       <= '0;
            cpu_rdata     <= '0;
            cpu_ready     <= 1'b0;
            cpu_busy      <= 1'b0;
            l2_request    <= 1'b0;
            l2_write_en   <= 1'b0;
            l2_paddr      <= '0;
            l2_write_data <= '0;
        end else begin
            cpu_ready  <= 1'b0;
            l2_request <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cpu_req) begin
                        addr_q   <= cpu_addr[31:2];
                        we_q     <= cpu_we;
                        wdata_q  <= cpu_wdata;
                        cpu_busy <= 1'b1;
                        state    <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (hit) begin
                        if (!we_q) begin
                            cpu_rdata <= word_slice(rd_line, word_sel);
                        end
                        cpu_ready <= 1'b1;
                        cpu_busy  <= 1'b0;
                        state     <= S_IDLE;
                    end else if (rd_valid && rd_dirty) begin
                        l2_request    <= 1'b1;
                        l2_write_en   <= 1'b1;
                        l2_paddr      <= {rd_tag, idx_q, {OFF_W{1'b0}}};
                        l2_write_data <= rd_line;
                        state         <= S_WB_REQ;
                    end else begin
                        l2_request  <= 1'b1;
                        l2_write_en <= 1'b0;
                        l2_paddr    <= {tag_q, idx_q, {OFF_W{1'b0}}};
                        state       <= S_FILL_REQ;
                    end
                end
                S_WB_REQ: begin
                    state <= S_WB_WAIT;
                end
                S_WB_WAIT: begin
                    if (done_rise) begin
                        l2_request  <= 1'b1;
                        l2_write_en <= 1'b0;
                        l2_paddr    <= {tag_q, idx_q, {OFF_W{1'b0}}};
                        state       <= S_FILL_REQ;
                    end
                end
                S_FILL_REQ: begin
                    state <= S_FILL_WAIT;
                end
                S_FILL_WAIT: begin
                    if (done_rise) begin
                        if (!we_q) begin
                            cpu_rdata <= word_slice(l2_data_out, word_sel);
                        end
                        cpu_ready <= 1'b1;
                        state     <= S_RESPOND;
                    end
                end
                S_RESPOND: begin
                    cpu_busy <= 1'b0;
                    state    <= S_IDLE;
                end
                default: begin
                    cpu_busy <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l1_dcache.sv
// Directed, table-driven bench for l1_dcache with a behavioural L2 responder.
module tb_l1_dcache;

    logic         clk;
    logic         reset;
    logic         cpu_req;
    logic         cpu_we;
    logic [31:0]  cpu_addr;
    logic [31:0]  cpu_wdata;
    logic [31:0]  cpu_rdata;
    logic         cpu_ready;
    logic         cpu_busy;
    logic         l2_request;
    logic         l2_write_en;
    logic [31:0]  l2_paddr;
    logic [511:0] l2_write_data;
    logic [511:0] l2_data_out;
    logic         l2_done;

    int n_checks = 0;
    int n_errors = 0;

    l1_dcache #(.SETS(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .cpu_req       (cpu_req),
        .cpu_we        (cpu_we),
        .cpu_addr      (cpu_addr),
        .cpu_wdata     (cpu_wdata),
        .cpu_rdata     (cpu_rdata),
        .cpu_ready     (cpu_ready),
        .cpu_busy      (cpu_busy),
        .l2_request    (l2_request),
        .l2_write_en   (l2_write_en),
        .l2_paddr      (l2_paddr),
        .l2_write_data (l2_write_data),
        .l2_data_out   (l2_data_out),
        .l2_done       (l2_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- L2 model ----------------
    typedef struct {
        logic         we;
        logic [31:0]  paddr;
        logic [511:0] wdata;
    } l2_req_t;

    l2_req_t      req_log[$];
    logic [511:0] l2_mem [logic [31:0]];
    int           l2_lat    = 2;
    bit           hold_done = 0;
    bit           pending   = 0;
    int           cnt       = 0;

    // Untouched lines read back as word i = line address + i.
    function automatic logic [511:0] pattern(input logic [31:0] p);
        logic [511:0] l;
        for (int i = 0; i < 16; i++) l[511-32*i -: 32] = p + i;
        return l;
    endfunction

    function automatic logic [511:0] l2_read(input logic [31:0] p);
        if (l2_mem.exists(p)) return l2_mem[p];
        return pattern(p);
    endfunction

    initial begin
        l2_done     = 1'b0;
        l2_data_out = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pending = 0;
                l2_done = 1'b0;
            end else begin
                if (l2_done && !hold_done && !pending) l2_done = 1'b0;
                if (l2_request) begin
                    req_log.push_back('{l2_write_en, l2_paddr, l2_write_data});
                    if (l2_write_en) l2_mem[l2_paddr] = l2_write_data;
                    else             l2_data_out = l2_read(l2_paddr);
                    pending = 1;
                    cnt     = l2_lat;
                end else if (pending) begin
                    if (cnt > 0)      cnt--;
                    else if (l2_done) l2_done = 1'b0;   // force a fresh rising edge
                    else begin
                        l2_done = 1'b1;
                        pending = 0;
                    end
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          intrude;    // pulse a store request while busy
        bit          hold;       // L2 leaves l2_done high after completing
        logic [31:0] exp_rdata;
        int          exp_lat;    // edges from acceptance to cpu_ready seen
        int          exp_nreq;
        logic        r0_we;
        logic [31:0] r0_addr;
        int          wb_word;
        logic [31:0] wb_val;
        logic [31:0] r1_addr;
    } vec_t;

    task automatic run_vec(input vec_t v, input string tag);
        int          cycles;
        int          base;
        int          nreq;
        logic [511:0] wl;
        hold_done = v.hold;
        @(negedge clk);
        base      = req_log.size();
        cpu_req   = 1'b1;
        cpu_we    = v.we;
        cpu_addr  = v.addr;
        cpu_wdata = v.wdata;
        @(negedge clk);
        cpu_req = 1'b0;
        cycles  = 1;
        while (!cpu_ready && cycles < 200) begin
            @(negedge clk);
            cycles++;
            if (v.intrude && cycles == 3) begin
                cpu_req   = 1'b1;
                cpu_we    = 1'b1;
                cpu_wdata = 32'hFFFF_FFFF;
            end else begin
                cpu_req = 1'b0;
            end
        end
        cpu_req = 1'b0;
        check({tag, " ready_seen"}, 64'(cpu_ready), 64'd1);
        check({tag, " latency"}, 64'(cycles), 64'(v.exp_lat));
        if (!v.we) check({tag, " rdata"}, 64'(cpu_rdata), 64'(v.exp_rdata));
        @(negedge clk);
        check({tag, " ready_pulse_ends"}, 64'(cpu_ready), 64'd0);
        nreq = req_log.size() - base;
        check({tag, " l2_requests"}, 64'(nreq), 64'(v.exp_nreq));
        if (nreq >= 1 && v.exp_nreq >= 1) begin
            check({tag, " req0_we"}, 64'(req_log[base].we), 64'(v.r0_we));
            check({tag, " req0_paddr"}, 64'(req_log[base].paddr), 64'(v.r0_addr));
            if (v.r0_we) begin
                wl = req_log[base].wdata;
                check({tag, " wb_word"}, 64'(wl[511-32*v.wb_word -: 32]), 64'(v.wb_val));
            end
        end
        if (nreq >= 2 && v.exp_nreq >= 2) begin
            check({tag, " req1_we"}, 64'(req_log[base+1].we), 64'd0);
            check({tag, " req1_paddr"}, 64'(req_log[base+1].paddr), 64'(v.r1_addr));
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " cpu_ready"}, 64'(cpu_ready), 64'd0);
        check({tag, " cpu_busy"}, 64'(cpu_busy), 64'd0);
        check({tag, " cpu_rdata"}, 64'(cpu_rdata), 64'd0);
        check({tag, " l2_request"}, 64'(l2_request), 64'd0);
        check({tag, " l2_write_en"}, 64'(l2_write_en), 64'd0);
        check({tag, " l2_paddr"}, 64'(l2_paddr), 64'd0);
        check({tag, " l2_write_data_zero"}, 64'(l2_write_data == '0), 64'd1);
    endtask

    vec_t vecs[16];
    vec_t post[2];

    initial begin
        logic [511:0] seed;
        int           guard;

        // Line 0x1040 carries 0xDEADBEEF in word 1 (bits [479:448]).
        seed = pattern(32'h0000_1040);
        seed[479:448] = 32'hDEAD_BEEF;
        l2_mem[32'h0000_1040] = seed;

        //            we    addr           wdata          int hld exp_rdata      lat nrq r0we  r0_addr        wbw wb_val         r1_addr
        vecs[0]  = '{1'b0, 32'h0000_1044, 32'h0,         0, 0, 32'hDEAD_BEEF,  6, 1, 1'b0, 32'h0000_1040, 0, 32'h0,         32'h0};
        vecs[1]  = '{1'b0, 32'h0000_1048, 32'h0,         0, 0, 32'h0000_1042,  2, 0, 1'b0, 32'h0,         0, 32'h0,         32'h0};
        vecs[2]  = '{1'b1, 32'h0000_1044, 32'h1234_5678, 0, 0, 32'h0,          2, 0, 1'b0, 32'h0,         0, 32'h0,         32'h0};
        vecs[3]  = '{1'b0, 32'h0000_1044, 32'h0,         0, 0, 32'h1234_5678,  2, 0, 1'b0, 32'h0,         0, 32'h0,         32'h0};
        vecs[4]  = '{1'b0, 32'h0000_1440, 32'h0,         0, 0, 32'h0000_1440, 10, 2, 1'b1, 32'h0000_1040, 1, 32'h1234_5678, 32'h0000_1440};
        vecs[5]  = '{1'b0, 32'h0000_1044, 32'h0,         0, 0, 32'h1234_5678,  6, 1, 1'b0, 32'h0000_1040, 0, 32'h0,         32'h0};
        vecs[6]  = '{1'b1, 32'h0000_0108, 32'hCAFE_F00D, 0, 0, 32'h0,          6, 1, 1'b0, 32'h0000_0100, 0, 32'h0,         32'h0};
        vecs[7]  = '{1'b1, 32'h0000_010C, 32'h0BAD_F00D, 0, 0, 32'h0,          2, 0, 1'b0, 32'h0,         0, 32'h0,         32'h0};
        vecs[8]  = '{1'b0, 32'h0000_0108, 32'h0,         0, 0, 32'hCAFE_F00D,  2, 0, 1'b0, 32'h0,         0, 32'h0,         32'h0};
        vecs[9]  = '{1'b0, 32'h0000_010C, 32'h0,         0, 0, 32'h0BAD_F00D,  2, 0, 1'b0, 32'h0,         0, 32'h0,         32'h0};
        vecs[10] = '{1'b0, 32'h0000_0508, 32'h0,         0, 0, 32'h0000_0502, 10, 2, 1'b1, 32'h0000_0100, 2, 32'hCAFE_F00D, 32'h0000_0500};
        vecs[11] = '{1'b0, 32'h0000_0180, 32'h0,         1, 0, 32'h0000_0180,  6, 1, 1'b0, 32'h0000_0180, 0, 32'h0,         32'h0};
        vecs[12] = '{1'b0, 32'h0000_0180, 32'h0,         0, 0, 32'h0000_0180,  2, 0, 1'b0, 32'h0,         0, 32'h0,         32'h0};
        vecs[13] = '{1'b0, 32'h0000_2080, 32'h0,         0, 1, 32'h0000_2080,  6, 1, 1'b0, 32'h0000_2080, 0, 32'h0,         32'h0};
        vecs[14] = '{1'b0, 32'h0000_30C4, 32'h0,         0, 1, 32'h0000_30C1,  7, 1, 1'b0, 32'h0000_30C0, 0, 32'h0,         32'h0};
        vecs[15] = '{1'b0, 32'h0000_0514, 32'h0,         0, 0, 32'h0000_0505,  2, 0, 1'b0, 32'h0,         0, 32'h0,         32'h0};

        // After a reset taken in FILL_WAIT both lines must miss again.
        post[0]  = '{1'b0, 32'h0000_1044, 32'h0,         0, 0, 32'h1234_5678,  6, 1, 1'b0, 32'h0000_1040, 0, 32'h0,         32'h0};
        post[1]  = '{1'b0, 32'h0000_0240, 32'h0,         0, 0, 32'h0000_0240,  6, 1, 1'b0, 32'h0000_0240, 0, 32'h0,         32'h0};

        reset     = 1'b1;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        reset = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("v%0d", i));

        // Reset while waiting on a slow fill.
        l2_lat = 20;
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 32'h0000_0240;
        @(negedge clk);
        cpu_req = 1'b0;
        guard   = 0;
        while (!l2_request && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("midreset fill_req_seen", 64'(l2_request), 64'd1);
        check("midreset fill_paddr", 64'(l2_paddr), 64'h0000_0240);
        repeat (3) @(negedge clk);
        check("midreset busy_before", 64'(cpu_busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        check_outputs_zero("midreset");
        reset  = 1'b0;
        l2_lat = 2;
        repeat (2) @(negedge clk);
        check("midreset idle_after", 64'(cpu_busy), 64'd0);

        foreach (post[i]) run_vec(post[i], $sformatf("post%0d", i));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
